garage_door_supervisor: RTL and testbench

//  Top-level sequencer for the garage door motor. Merges two push-button requesters (remote, wall) into
//  one toggle command and drives UP_M/DN_M with mandatory motor dead-time between motions.

---
 rtl/garage_door_supervisor_pkg.sv | 18 +
 rtl/garage_door_supervisor_req_edge_merge.sv | 26 ++
 rtl/garage_door_supervisor.sv | 114 +++++++++++
 tb/tb_garage_door_supervisor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/garage_door_supervisor_pkg.sv
// garage_door_pkg: shared state encoding and direction constants for the garage door supervisor
package garage_door_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        CLOSED  = 3'd1,
        OPEN    = 3'd2,
        DEAD    = 3'd3,
        MV_UP   = 3'd4,
        MV_DN   = 3'd5,
        STOPPED = 3'd6,
        FAULT   = 3'd7
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/garage_door_supervisor_req_edge_merge.sv
// req_edge_merge: rising-edge detect on both buttons, merged into one single-cycle press pulse
module req_edge_merge (
    input  logic CLK,
    input  logic RST,
    input  logic Remote_Req,
    input  logic Wall_Req,
    output logic press
);

    logic remote_q;
    logic wall_q;

    // previous button levels for edge detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            remote_q <= 1'b0;
            wall_q   <= 1'b0;
        end else begin
            remote_q <= Remote_Req;
            wall_q   <= Wall_Req;
        end
    end

    assign press = (Remote_Req & ~remote_q) | (Wall_Req & ~wall_q);

endmodule

// File: rtl/garage_door_supervisor.sv
// garage_door_supervisor: door motor sequencer with dead-time, reversal, auto-close and travel timeout
module garage_door_supervisor
    import garage_door_pkg::*;
#(
    parameter int DEADTIME_CYC     = 4,
    parameter int AUTOCLOSE_CYC    = 16,
    parameter int MOVE_TIMEOUT_CYC = 64,
    parameter int CNT_W            = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic Remote_Req,
    input  logic Wall_Req,
    input  logic Obstruct,
    input  logic UP_Max,
    input  logic DN_Max,
    output logic UP_M,
    output logic DN_M,
    output logic Door_Open,
    output logic Fault
);

    state_t             state, state_n;
    logic               dir, dir_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               press;
    logic               hold;

    req_edge_merge u_req (
        .CLK        (CLK),
        .RST        (RST),
        .Remote_Req (Remote_Req),
        .Wall_Req   (Wall_Req),
        .press      (press)
    );

    // state, direction and shared counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= INIT;
            dir   <= DIR_UP;
            cnt   <= '0;
        end else begin
            state <= state_n;
            dir   <= dir_n;
            cnt   <= cnt_n;
        end
    end

    // next-state, direction and counter; hold pins the counter at zero while blocked
    always_comb begin
        state_n = state;
        dir_n   = dir;
        hold    = 1'b0;
        case (state)
            INIT: begin
                if (UP_Max && DN_Max) state_n = FAULT;
                else if (UP_Max)      state_n = OPEN;
                else if (DN_Max)      state_n = CLOSED;
                else begin
                    state_n = STOPPED;
                    dir_n   = DIR_UP;
                end
            end
            CLOSED: begin
                if (press) begin
                    state_n = DEAD;
                    dir_n   = DIR_UP;
                end
            end
            OPEN: begin
                hold = Obstruct;
                if (press || (AUTOCLOSE_CYC != 0 && cnt == CNT_W'(AUTOCLOSE_CYC - 1) && !Obstruct)) begin
                    state_n = DEAD;
                    dir_n   = DIR_DN;
                end
            end
            DEAD: begin
                hold = (dir == DIR_DN) && Obstruct;
                if (!hold && cnt == CNT_W'(DEADTIME_CYC - 1)) state_n = (dir == DIR_UP) ? MV_UP : MV_DN;
            end
            MV_UP: begin
                if (UP_Max && DN_Max)                          state_n = FAULT;
                else if (UP_Max)                               state_n = OPEN;
                else if (press)                                state_n = STOPPED;
                else if (cnt == CNT_W'(MOVE_TIMEOUT_CYC - 1))  state_n = FAULT;
            end
            MV_DN: begin
                if (UP_Max && DN_Max) state_n = FAULT;
                else if (DN_Max)      state_n = CLOSED;
                else if (Obstruct) begin
                    state_n = DEAD;
                    dir_n   = DIR_UP;
                end
                else if (press)                                state_n = STOPPED;
                else if (cnt == CNT_W'(MOVE_TIMEOUT_CYC - 1))  state_n = FAULT;
            end
            STOPPED: begin
                if (press) begin
                    state_n = DEAD;
                    dir_n   = ~dir;
                end
            end
            FAULT: ;
        endcase
        cnt_n = (state_n != state || hold) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
    end

    assign UP_M      = (state == MV_UP);
    assign DN_M      = (state == MV_DN);
    assign Door_Open = (state == OPEN);
    assign Fault     = (state == FAULT);

endmodule

// File: tb/tb_garage_door_supervisor.sv
// tb_garage_door_supervisor: scoreboard bench; stimulus queues expected outputs per cycle, monitor compares
module tb_garage_door_supervisor;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Remote_Req = 1'b0;
    logic Wall_Req = 1'b0;
    logic Obstruct = 1'b0;
    logic UP_Max = 1'b0;
    logic DN_Max = 1'b0;
    logic UP_M, DN_M, Door_Open, Fault;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;

    int         q_cyc[$];
    logic [3:0] q_exp[$];
    string      q_name[$];

    garage_door_supervisor dut (
        .CLK        (CLK),
        .RST        (RST),
        .Remote_Req (Remote_Req),
        .Wall_Req   (Wall_Req),
        .Obstruct   (Obstruct),
        .UP_Max     (UP_Max),
        .DN_Max     (DN_Max),
        .UP_M       (UP_M),
        .DN_M       (DN_M),
        .Door_Open  (Door_Open),
        .Fault      (Fault)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // monitor: sample mid-cycle, check motor exclusivity and pop expectations due this cycle
    always @(negedge CLK) begin
        logic [3:0] o;
        o = {UP_M, DN_M, Door_Open, Fault};
        vectors++;
        if (UP_M && DN_M) begin
            errors++;
            $display("FAIL both_motors cyc=%0d got UP_M=%b DN_M=%b want not both high", cyc, UP_M, DN_M);
        end
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            vectors++;
            if (q_cyc[0] != cyc || o !== q_exp[0]) begin
                errors++;
                $display("FAIL %s cyc=%0d (due %0d) got {UP,DN,OPEN,FLT}=%b want %b",
                         q_name[0], cyc, q_cyc[0], o, q_exp[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_exp.pop_front());
            void'(q_name.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_at(input int d, input logic [3:0] e, input string n);
        q_cyc.push_back(cyc + d);
        q_exp.push_back(e);
        q_name.push_back(n);
    endtask

    task automatic press(input logic r, input logic w);
        Remote_Req = r;
        Wall_Req   = w;
        tick();
        Remote_Req = 1'b0;
        Wall_Req   = 1'b0;
    endtask

    initial begin
        // 1: closed -> open with dead-time latency
        DN_Max = 1'b1;
        tick(); tick();
        expect_at(0, 4'b0000, "reset");
        RST = 1'b0;
        tick();
        expect_at(0, 4'b0000, "closed");
        press(1'b0, 1'b1);
        DN_Max = 1'b0;
        expect_at(0, 4'b0000, "dead0");
        expect_at(3, 4'b0000, "dead3");
        expect_at(4, 4'b1000, "up_on");
        repeat (4) tick();
        repeat (5) tick();
        UP_Max = 1'b1;
        tick();
        expect_at(0, 4'b0010, "opened");
        // 2: auto-close after 16 cycles, then close on limit
        expect_at(15, 4'b0010, "open_hold");
        expect_at(16, 4'b0000, "autoclose_dead");
        expect_at(19, 4'b0000, "autoclose_dead3");
        expect_at(20, 4'b0100, "dn_on");
        repeat (16) tick();
        UP_Max = 1'b0;
        repeat (4) tick();
        repeat (3) tick();
        DN_Max = 1'b1;
        tick();
        expect_at(0, 4'b0000, "closed_by_limit");
        // 3: limit beats press, obstruction reversal
        press(1'b1, 1'b0);
        DN_Max = 1'b0;
        expect_at(4, 4'b1000, "up_again");
        repeat (4) tick();
        UP_Max = 1'b1;
        Remote_Req = 1'b1;
        tick();
        Remote_Req = 1'b0;
        expect_at(0, 4'b0010, "limit_beats_press");
        tick();
        press(1'b1, 1'b0);
        UP_Max = 1'b0;
        expect_at(4, 4'b0100, "dn_again");
        repeat (4) tick();
        repeat (2) tick();
        Obstruct = 1'b1;
        tick();
        expect_at(0, 4'b0000, "obstruct_stop");
        Obstruct = 1'b0;
        expect_at(3, 4'b0000, "rev_dead3");
        expect_at(4, 4'b1000, "rev_up");
        repeat (4) tick();
        // 4: mid-travel stop, reversed restart delayed by obstruction in dead-time
        repeat (9) tick();
        press(1'b0, 1'b1);
        expect_at(0, 4'b0000, "mid_stop");
        repeat (5) tick();
        expect_at(0, 4'b0000, "stopped_holds");
        press(1'b0, 1'b1);
        Obstruct = 1'b1;
        expect_at(6, 4'b0000, "dn_wait_obstruct");
        expect_at(7, 4'b0100, "reversed_dn");
        repeat (3) tick();
        Obstruct = 1'b0;
        repeat (4) tick();
        DN_Max = 1'b1;
        tick();
        expect_at(0, 4'b0000, "closed3");
        // 5: travel timeout -> sticky fault
        press(1'b0, 1'b1);
        DN_Max = 1'b0;
        expect_at(4, 4'b1000, "up3");
        expect_at(67, 4'b1000, "pre_timeout");
        expect_at(68, 4'b0001, "timeout_fault");
        repeat (68) tick();
        press(1'b0, 1'b1);
        repeat (5) tick();
        expect_at(0, 4'b0001, "fault_sticky");
        // 6: reset recovery, dual press, reset mid-motion, stopped reversal from INIT
        RST = 1'b1;
        DN_Max = 1'b1;
        tick();
        expect_at(0, 4'b0000, "reset_from_fault");
        RST = 1'b0;
        tick();
        press(1'b1, 1'b1);
        DN_Max = 1'b0;
        expect_at(3, 4'b0000, "dual_dead3");
        expect_at(4, 4'b1000, "dual_press_up");
        repeat (4) tick();
        UP_Max = 1'b1;
        tick();
        expect_at(0, 4'b0010, "open2");
        tick();
        press(1'b1, 1'b0);
        UP_Max = 1'b0;
        expect_at(4, 4'b0100, "dn3");
        repeat (4) tick();
        repeat (2) tick();
        RST = 1'b1;
        tick();
        expect_at(0, 4'b0000, "rst_mid_dn");
        RST = 1'b0;
        tick();
        expect_at(0, 4'b0000, "init_stopped");
        tick();
        press(1'b0, 1'b1);
        expect_at(3, 4'b0000, "stopped_dead3");
        expect_at(4, 4'b0100, "stopped_rev_dn");
        repeat (4) tick();
        RST = 1'b1;
        UP_Max = 1'b1;
        DN_Max = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        expect_at(0, 4'b0001, "init_both_limits");
        repeat (3) tick();
        vectors++;
        if (q_cyc.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got %0d left want 0", q_cyc.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
